// File: rtl/spi_master_core.sv
// spi_master_core
// Byte-oriented SPI master, mode 0 (CPOL=0, CPHA=0).
// Shifts one byte out on dout while capturing din, drives an active-low
// slave select and pulses done for one clock when the byte completes.
//
// Ports:
//   clk    in   system clock, rising edge
//   rstb   in   asynchronous active-low reset
//   mlb    in   bit order (1 = MSB first, 0 = LSB first), sampled at start
//   start  in   level request; a byte begins whenever start=1 while idle
//   tdat   in   [7:0] transmit byte, latched at start
//   cdiv   in   [1:0] SCK divider: half-period = 2^(cdiv+1) clk cycles
//   din    in   serial data from slave (MISO)
//   ss     out  slave select, active low
//   sck    out  serial clock, idles low
//   dout   out  serial data to slave (MOSI)
//   done   out  one-clk pulse at end of a byte
//   rdata  out  [7:0] received byte, updated with done
module spi_master_core (
  input  logic       clk,
  input  logic       rstb,
  input  logic       mlb,
  input  logic       start,
  input  logic [7:0] tdat,
  input  logic [1:0] cdiv,
  input  logic       din,
  output logic       ss,
  output logic       sck,
  output logic       dout,
  output logic       done,
  output logic [7:0] rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] div_q, div_d;     // clk count within the current half-period
  logic [3:0] half_q, half_d;   // half-period index within the byte (0..15)
  logic [1:0] cdiv_q, cdiv_d;
  logic       msb_q, msb_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic       ss_q, ss_d;
  logic       sck_q, sck_d;
  logic       dout_q, dout_d;
  logic       done_q, done_d;
  logic [7:0] rdata_q, rdata_d;

  logic [3:0] div_top;
  logic       half_end;
  logic [7:0] tx_shift;
  logic [7:0] rx_shift;

  // Last count value of a half-period: H-1 with H = 2^(cdiv+1).
  always_comb begin
    case (cdiv_q)
      2'd0:    div_top = 4'd1;
      2'd1:    div_top = 4'd3;
      2'd2:    div_top = 4'd7;
      default: div_top = 4'd15;
    endcase
  end

  assign half_end = (div_q == div_top);
  assign tx_shift = msb_q ? {tx_q[6:0], 1'b0} : {1'b0, tx_q[7:1]};
  // Receive uses the same order as transmit so a loopback returns the byte.
  assign rx_shift = msb_q ? {rx_q[6:0], din} : {din, rx_q[7:1]};

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    half_d  = half_q;
    cdiv_d  = cdiv_q;
    msb_d   = msb_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    ss_d    = ss_q;
    sck_d   = sck_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        ss_d  = 1'b1;
        sck_d = 1'b0;
        if (start) begin
          tx_d    = tdat;
          msb_d   = mlb;
          cdiv_d  = cdiv;
          div_d   = 4'd0;
          half_d  = 4'd0;
          rx_d    = 8'h00;
          ss_d    = 1'b0;
          dout_d  = mlb ? tdat[7] : tdat[0];
          state_d = SEND;
        end
      end

      SEND: begin
        if (half_end) begin
          div_d  = 4'd0;
          half_d = half_q + 4'd1;
          if (!sck_q) begin
            // Rising SCK: capture MISO.
            sck_d = 1'b1;
            rx_d  = rx_shift;
          end else begin
            sck_d = 1'b0;
            if (half_q == 4'd15) begin
              // Falling edge after the 8th bit ends the byte; dout keeps
              // the last bit.
              state_d = FINISH;
              ss_d    = 1'b1;
              done_d  = 1'b1;
              rdata_d = rx_q;
            end else begin
              tx_d   = tx_shift;
              dout_d = msb_q ? tx_shift[7] : tx_shift[0];
            end
          end
        end else begin
          div_d = div_q + 4'd1;
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        ss_d    = 1'b1;
        sck_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      div_q   <= 4'd0;
      half_q  <= 4'd0;
      cdiv_q  <= 2'd0;
      msb_q   <= 1'b0;
      tx_q    <= 8'h00;
      rx_q    <= 8'h00;
      ss_q    <= 1'b1;
      sck_q   <= 1'b0;
      dout_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      half_q  <= half_d;
      cdiv_q  <= cdiv_d;
      msb_q   <= msb_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      ss_q    <= ss_d;
      sck_q   <= sck_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  assign ss    = ss_q;
  assign sck   = sck_q;
  assign dout  = dout_q;
  assign done  = done_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_spi_master_core.sv
// Testbench for spi_master_core: randomized and directed bytes; a monitor
// observes the SPI pins and done, and compares each completed byte against
// an expectation queued when the stimulus requested it.
module tb_spi_master_core;

  logic       clk;
  logic       rstb;
  logic       mlb;
  logic       start;
  logic [7:0] tdat;
  logic [1:0] cdiv;
  logic       din;
  logic       ss;
  logic       sck;
  logic       dout;
  logic       done;
  logic [7:0] rdata;

  spi_master_core dut (
    .clk   (clk),
    .rstb  (rstb),
    .mlb   (mlb),
    .start (start),
    .tdat  (tdat),
    .cdiv  (cdiv),
    .din   (din),
    .ss    (ss),
    .sck   (sck),
    .dout  (dout),
    .done  (done),
    .rdata (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
    logic       msb;
    logic [1:0] cdiv;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Slave model: either loops MOSI back, or presents bit i of cur_pat (in
  // the chosen bit order) before the (i+1)-th rising SCK.
  logic       loop;
  logic [7:0] cur_pat;
  logic       cur_msb;
  int         rise_cnt;
  logic [2:0] pat_idx;

  always_comb begin
    pat_idx = (rise_cnt > 7) ? 3'd7 : rise_cnt[2:0];
    if (loop) din = dout;
    else      din = cur_msb ? cur_pat[3'd7 - pat_idx] : cur_pat[pat_idx];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic prev_ss, prev_sck, prev_done, have_prev;
    int   low_cnt, since_rise, gap, h;
    logic bits [8];
    int   per  [8];
    logic [7:0] tx_cap;
    logic per_ok;
    exp_t e;
    prev_ss = 1'b1; prev_sck = 1'b0; prev_done = 1'b0; have_prev = 1'b0;
    low_cnt = 0; since_rise = 0; gap = 0; rise_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rstb) begin
        prev_ss = 1'b1; prev_sck = 1'b0; prev_done = 1'b0; have_prev = 1'b0;
        rise_cnt = 0; gap = 0;
        continue;
      end
      if (prev_done) check("done_width", {31'd0, done}, 32'd0);
      if (prev_ss && !ss) begin
        if (have_prev) check("ss_gap_ge2", {31'd0, gap >= 2}, 32'd1);
        low_cnt = 0; rise_cnt = 0; since_rise = 0;
      end
      if (!ss) begin
        low_cnt++;
        since_rise++;
        if (sck && !prev_sck) begin
          if (rise_cnt < 8) begin
            bits[rise_cnt] = dout;
            per[rise_cnt]  = since_rise;
          end
          rise_cnt++;
          since_rise = 0;
        end
      end else begin
        gap++;
      end
      if (done) begin
        check("done_expected", {31'd0, sb_q.size() != 0}, 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          h = 2 << e.cdiv;
          tx_cap = 8'h00;
          for (int i = 0; i < 8; i++) begin
            if (e.msb) tx_cap[7 - i] = bits[i];
            else       tx_cap[i]     = bits[i];
          end
          per_ok = 1'b1;
          for (int i = 1; i < 8; i++) if (per[i] != 2 * h) per_ok = 1'b0;
          $display("byte: cdiv=%0d msb=%0d tx=%02h (exp %02h) rdata=%02h (exp %02h) ss_low=%0d sck_rises=%0d",
                   e.cdiv, e.msb, tx_cap, e.tx, rdata, e.rx, low_cnt, rise_cnt);
          check("tx_bits",   {24'd0, tx_cap}, {24'd0, e.tx});
          check("rdata",     {24'd0, rdata},  {24'd0, e.rx});
          check("ss_low_len", low_cnt, 16 * h);
          check("sck_rises",  rise_cnt, 8);
          check("sck_period", {31'd0, per_ok}, 32'd1);
          check("idle_pins",  {30'd0, ss, sck}, 32'd2);
        end
        have_prev = 1'b1;
        gap = 1;
        rise_cnt = 0;
      end
      prev_ss = ss; prev_sck = sck; prev_done = done;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 2000);
    check(name, {31'd0, n < 2000}, 32'd1);
  endtask

  task automatic issue(input logic [7:0] t, input logic m, input logic [1:0] c,
                       input logic lp, input logic [7:0] pat);
    exp_t e;
    tdat = t; mlb = m; cdiv = c; loop = lp; cur_pat = pat; cur_msb = m;
    start = 1'b1;
    e.tx = t; e.rx = lp ? t : pat; e.msb = m; e.cdiv = c;
    sb_q.push_back(e);
  endtask

  task automatic run_byte(input logic [7:0] t, input logic m, input logic [1:0] c,
                          input logic lp, input logic [7:0] pat);
    @(negedge clk);
    issue(t, m, c, lp, pat);
    @(negedge clk);
    start = 1'b0;
    wait_done("done_timeout");
    repeat (2) @(negedge clk);
  endtask

  logic [7:0] stream_bytes [3];

  initial begin
    int n;
    rstb = 1'b0; start = 1'b1; tdat = 8'hFF; mlb = 1'b1; cdiv = 2'd0;
    loop = 1'b1; cur_pat = 8'h00; cur_msb = 1'b1;

    // Reset held with start asserted: pins stay at reset values.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("reset_pins", {20'd0, ss, sck, dout, done, rdata}, {20'd0, 4'b1000, 8'h00});
    end
    start = 1'b0;
    @(negedge clk);
    #1 rstb = 1'b1;

    // Directed bytes.
    run_byte(8'hA5, 1'b1, 2'd0, 1'b1, 8'h00);
    run_byte(8'h01, 1'b0, 2'd0, 1'b0, 8'hFF);
    for (int c = 1; c < 4; c++) run_byte(8'h5A ^ 8'(c), 1'b1, 2'(c), 1'b1, 8'h00);

    // Streaming: start held, tdat refreshed on each done.
    stream_bytes[0] = 8'h11; stream_bytes[1] = 8'h22; stream_bytes[2] = 8'h33;
    @(negedge clk);
    issue(stream_bytes[0], 1'b1, 2'd0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) begin
      wait_done("stream_timeout");
      if (i < 2) issue(stream_bytes[i + 1], 1'b1, 2'd0, 1'b1, 8'h00);
      else       start = 1'b0;
    end
    repeat (3) @(negedge clk);

    // Randomized bytes.
    for (int i = 0; i < 8; i++)
      run_byte(8'($urandom), 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), 8'($urandom));

    // Mid-transfer reset after three SCK rising edges.
    @(negedge clk);
    issue(8'h3C, 1'b1, 2'd1, 1'b1, 8'h00);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (rise_cnt < 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("rise3_timeout", {31'd0, n < 500}, 32'd1);
    #1 rstb = 1'b0;
    void'(sb_q.pop_back());
    #1 check("midreset_pins", {22'd0, ss, sck, done, rdata}, {22'd0, 3'b100, 8'h00});
    repeat (3) @(negedge clk);
    #1 rstb = 1'b1;
    run_byte(8'hC3, 1'b0, 2'd0, 1'b1, 8'h00);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
